// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if: two writeback request channels plus the shared RegisterFile write port and pending bitmap.
interface regfile_write_arbiter_if #(
  parameter int REG_BITS  = 32,
  parameter int ADDR_BITS = 5
);
  logic                      req0_valid;
  logic                      req0_ready;
  logic [ADDR_BITS-1:0]      req0_addr;
  logic [REG_BITS-1:0]       req0_data;
  logic                      req1_valid;
  logic                      req1_ready;
  logic [ADDR_BITS-1:0]      req1_addr;
  logic [REG_BITS-1:0]       req1_data;
  logic                      we3;
  logic [ADDR_BITS-1:0]      a3;
  logic [REG_BITS-1:0]       wd3;
  logic [1:0]                grant;
  logic [2**ADDR_BITS-1:0]   pending;
  modport master (
    output req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    input  req0_ready, req1_ready, we3, a3, wd3, grant, pending
  );
  modport slave (
    input  req0_valid, req0_addr, req0_data, req1_valid, req1_addr, req1_data,
    output req0_ready, req1_ready, we3, a3, wd3, grant, pending
  );
endinterface

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin share of the RegisterFile write port between two 1-entry writeback buffers.
module regfile_write_arbiter #(
  parameter int REG_BITS  = 32,
  parameter int ADDR_BITS = 5
) (
  input logic                     clk,
  input logic                     rst_n,
  regfile_write_arbiter_if.slave  bus
);
  localparam logic PRI0 = 1'b0;
  localparam logic PRI1 = 1'b1;
  logic                  full0, full1, rr;
  logic [ADDR_BITS-1:0]  addr0, addr1;
  logic [REG_BITS-1:0]   data0, data1;
  logic                  sel0, sel1, acc0, acc1;
  logic [2**ADDR_BITS-1:0] pend;
  assign sel0 = full0 & (!full1 | rr == PRI0);
  assign sel1 = full1 & (!full0 | rr == PRI1);
  assign bus.req0_ready = !full0 | sel0;
  assign bus.req1_ready = !full1 | sel1;
  // x0 writes complete the handshake but never occupy a buffer
  assign acc0 = bus.req0_valid & bus.req0_ready & (|bus.req0_addr);
  assign acc1 = bus.req1_valid & bus.req1_ready & (|bus.req1_addr);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full0     <= 1'b0;
      full1     <= 1'b0;
      addr0     <= '0;
      addr1     <= '0;
      data0     <= '0;
      data1     <= '0;
      rr        <= PRI0;
      bus.we3   <= 1'b0;
      bus.a3    <= '0;
      bus.wd3   <= '0;
      bus.grant <= 2'b00;
    end else begin
      full0     <= acc0 | (full0 & !sel0);
      full1     <= acc1 | (full1 & !sel1);
      if (acc0) begin
        addr0 <= bus.req0_addr;
        data0 <= bus.req0_data;
      end
      if (acc1) begin
        addr1 <= bus.req1_addr;
        data1 <= bus.req1_data;
      end
      bus.we3   <= sel0 | sel1;
      bus.grant <= {sel1, sel0};
      if (sel0 | sel1) begin
        bus.a3  <= sel0 ? addr0 : addr1;
        bus.wd3 <= sel0 ? data0 : data1;
      end
      rr <= sel0 ? PRI1 : sel1 ? PRI0 : rr;
    end
  always_comb begin
    pend = '0;
    if (full0) pend[addr0] = 1'b1;
    if (full1) pend[addr1] = 1'b1;
    if (bus.we3) pend[bus.a3] = 1'b1;
    pend[0] = 1'b0;
  end
  assign bus.pending = pend;
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter: directed and random checks of the write arbiter against a queue-based reference model.
module tb_regfile_write_arbiter;
  typedef struct packed {logic [4:0] a; logic [31:0] d;} wr_t;
  logic clk = 1'b0;
  logic rst_n;
  int   vecs = 0;
  int   errs = 0;
  wr_t  q0[$];
  wr_t  q1[$];
  int   last;
  logic m_we;
  logic [4:0]  m_a3;
  logic [31:0] m_wd;
  logic [1:0]  m_gr;
  logic hs0, hs1;
  regfile_write_arbiter_if #(.REG_BITS(32), .ADDR_BITS(5)) bus ();
  regfile_write_arbiter #(.REG_BITS(32), .ADDR_BITS(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  // the source that did not win last time gets the tie; source 0 wins the first tie
  function automatic int pick();
    if (q0.size() != 0 && q1.size() != 0) return 1 - last;
    if (q0.size() != 0) return 0;
    if (q1.size() != 0) return 1;
    return -1;
  endfunction
  function automatic logic [73:0] exp_vec();
    logic [31:0] pd;
    int p;
    pd = '0;
    p = pick();
    foreach (q0[i]) pd[q0[i].a] = 1'b1;
    foreach (q1[i]) pd[q1[i].a] = 1'b1;
    if (m_we) pd[m_a3] = 1'b1;
    pd[0] = 1'b0;
    return {q0.size() == 0 || p == 0, q1.size() == 0 || p == 1, m_we, m_a3, m_wd, m_gr, pd};
  endfunction
  function automatic logic [73:0] obs_vec();
    return {bus.req0_ready, bus.req1_ready, bus.we3, bus.a3, bus.wd3, bus.grant, bus.pending};
  endfunction
  function automatic void model_reset();
    q0.delete();
    q1.delete();
    last = 1;
    m_we = 1'b0;
    m_a3 = '0;
    m_wd = '0;
    m_gr = 2'b00;
  endfunction
  task automatic drive(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] a1, input logic [31:0] d1);
    bus.req0_valid = v0; bus.req0_addr = a0; bus.req0_data = d0;
    bus.req1_valid = v1; bus.req1_addr = a1; bus.req1_data = d1;
  endtask
  task automatic tick();
    int p;
    wr_t w;
    p = pick();
    hs0 = bus.req0_valid && (q0.size() == 0 || p == 0);
    hs1 = bus.req1_valid && (q1.size() == 0 || p == 1);
    w = '0;
    @(posedge clk);
    if (p == 0) w = q0.pop_front();
    if (p == 1) w = q1.pop_front();
    m_we = p >= 0;
    m_gr = p == 0 ? 2'b01 : p == 1 ? 2'b10 : 2'b00;
    if (p >= 0) begin
      m_a3 = w.a;
      m_wd = w.d;
      last = p;
    end
    if (hs0 && bus.req0_addr != 0) q0.push_back({bus.req0_addr, bus.req0_data});
    if (hs1 && bus.req1_addr != 0) q1.push_back({bus.req1_addr, bus.req1_data});
    @(negedge clk);
  endtask
  task automatic apply_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_reset();
    apply_reset();
    vecs++;
    if (obs_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL reset_model got=%h exp=%h", obs_vec(), exp_vec());
    end
    vecs++;
    if ({bus.req0_ready, bus.req1_ready, bus.we3, bus.grant, bus.pending} !== {3'b110, 2'b00, 32'h0}) begin
      errs++;
      $display("FAIL reset_state got r=%b%b we3=%b grant=%b pending=%h exp r=11 we3=0 grant=00 pending=0",
               bus.req0_ready, bus.req1_ready, bus.we3, bus.grant, bus.pending);
    end
  endtask
  task automatic test_single();
    apply_reset();
    drive(1, 5, 13, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    vecs++;
    if (bus.pending !== 32'h20 || bus.we3 !== 1'b0) begin
      errs++;
      $display("FAIL single_pending got pending=%h we3=%b exp pending=00000020 we3=0", bus.pending, bus.we3);
    end
    tick();
    vecs++;
    if ({bus.we3, bus.a3, bus.wd3, bus.grant} !== {1'b1, 5'd5, 32'd13, 2'b01}) begin
      errs++;
      $display("FAIL single_issue got we3=%b a3=%0d wd3=%0d grant=%b exp we3=1 a3=5 wd3=13 grant=01",
               bus.we3, bus.a3, bus.wd3, bus.grant);
    end
    tick();
    vecs++;
    if (bus.we3 !== 1'b0 || bus.pending !== 32'h0 || obs_vec() !== exp_vec()) begin
      errs++;
      $display("FAIL single_done got=%h exp=%h", obs_vec(), exp_vec());
    end
  endtask
  task automatic test_contention();
    apply_reset();
    drive(1, 3, 32'hA, 1, 4, 32'hB);
    tick();
    drive(0, 0, 0, 0, 0, 0);
    vecs++;
    if ({bus.req0_ready, bus.req1_ready, bus.pending} !== {2'b10, 32'h18}) begin
      errs++;
      $display("FAIL contention_ready got r0=%b r1=%b pending=%h exp r0=1 r1=0 pending=00000018",
               bus.req0_ready, bus.req1_ready, bus.pending);
    end
    tick();
    vecs++;
    if ({bus.we3, bus.a3, bus.wd3, bus.grant, bus.req1_ready} !== {1'b1, 5'd3, 32'hA, 2'b01, 1'b1}) begin
      errs++;
      $display("FAIL contention_first got we3=%b a3=%0d wd3=%h grant=%b r1=%b exp 1 3 a 01 1",
               bus.we3, bus.a3, bus.wd3, bus.grant, bus.req1_ready);
    end
    tick();
    vecs++;
    if ({bus.we3, bus.a3, bus.wd3, bus.grant} !== {1'b1, 5'd4, 32'hB, 2'b10}) begin
      errs++;
      $display("FAIL contention_second got we3=%b a3=%0d wd3=%h grant=%b exp 1 4 b 10",
               bus.we3, bus.a3, bus.wd3, bus.grant);
    end
  endtask
  task automatic test_round_robin();
    int n0, n1, issued;
    logic [1:0] prev;
    apply_reset();
    n0 = 0; n1 = 0; issued = 0; prev = 2'b00;
    for (int c = 0; c < 40 && issued < 12; c++) begin
      drive(n0 < 6, 5'(2 * n0 + 1), 32'(100 + n0), n1 < 6, 5'(2 * n1 + 2), 32'(200 + n1));
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL rr_model cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      if (bus.we3 === 1'b1) begin
        issued++;
        if (prev != 2'b00) begin
          vecs++;
          if (bus.grant !== {prev[0], prev[1]}) begin
            errs++;
            $display("FAIL rr_alternate cyc=%0d got grant=%b exp grant=%b", c, bus.grant, {prev[0], prev[1]});
          end
        end
        prev = bus.grant;
      end else if (issued > 0 && issued < 12) begin
        vecs++;
        errs++;
        $display("FAIL rr_gap cyc=%0d got we3=0 exp we3=1", c);
      end
      tick();
      if (hs0 && n0 < 6) n0++;
      if (hs1 && n1 < 6) n1++;
    end
    vecs++;
    if (issued != 12) begin
      errs++;
      $display("FAIL rr_count got=%0d exp=12", issued);
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_x0_drop();
    apply_reset();
    drive(0, 0, 0, 1, 0, 32'hFFFF_FFFF);
    vecs++;
    if (bus.req1_ready !== 1'b1) begin
      errs++;
      $display("FAIL x0_ready got=%b exp=1", bus.req1_ready);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      vecs++;
      if (bus.we3 !== 1'b0 || bus.pending !== 32'h0 || obs_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL x0_idle i=%0d got we3=%b pending=%h exp we3=0 pending=0", i, bus.we3, bus.pending);
      end
      tick();
    end
  endtask
  task automatic test_streaming();
    apply_reset();
    for (int j = 0; j < 10; j++) begin
      drive(j < 8, 5'(j + 1), 32'(j + 50), 0, 0, 0);
      vecs++;
      if (bus.req0_ready !== 1'b1 || obs_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL stream_model j=%0d got=%h exp=%h", j, obs_vec(), exp_vec());
      end
      if (j >= 2) begin
        vecs++;
        if ({bus.we3, bus.a3, bus.grant} !== {1'b1, 5'(j - 1), 2'b01}) begin
          errs++;
          $display("FAIL stream_issue j=%0d got we3=%b a3=%0d grant=%b exp 1 %0d 01", j, bus.we3, bus.a3, bus.grant, j - 1);
        end
      end
      tick();
    end
  endtask
  task automatic test_random();
    apply_reset();
    for (int c = 0; c < 400; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom());
      vecs++;
      if (obs_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
      end
      tick();
    end
    drive(0, 0, 0, 0, 0, 0);
  endtask
  task automatic test_async_reset();
    apply_reset();
    drive(1, 7, 32'h77, 1, 9, 32'h99);
    tick();
    tick();
    vecs++;
    if (bus.we3 !== 1'b1 || bus.req1_ready === bus.req0_ready) begin
      errs++;
      $display("FAIL areset_busy got we3=%b r0=%b r1=%b exp we3=1 and one ready low", bus.we3, bus.req0_ready, bus.req1_ready);
    end
    #2;
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({bus.we3, bus.grant, bus.pending, bus.req0_ready, bus.req1_ready} !== {1'b0, 2'b00, 32'h0, 2'b11}) begin
      errs++;
      $display("FAIL areset_immediate got we3=%b grant=%b pending=%h r=%b%b exp 0 00 0 11",
               bus.we3, bus.grant, bus.pending, bus.req0_ready, bus.req1_ready);
    end
    model_reset();
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      vecs++;
      if (bus.we3 !== 1'b0 || obs_vec() !== exp_vec()) begin
        errs++;
        $display("FAIL areset_stale i=%0d got=%h exp=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask
  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_single();
    test_contention();
    test_round_robin();
    test_x0_drop();
    test_streaming();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
